alu_nibble_sequencer: RTL

Multi-cycle controller that drives the 4-bit CLA ALU slice (`claAdder4b`) nibble by nibble to perform WIDTH-bit and/or/add/sub/slt operations. It latches a request, streams one nibble per cycle through the combinational slice, and ripples the carry between cycles in a register. It then publishes the assembled result and flags with a done pulse. It sits between the processor control unit and a single shared slice instance.

---
 rtl/alu_nibble_sequencer_if.sv | 38 +++
 rtl/alu_nibble_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bus between the control unit and alu_nibble_sequencer.
// The ovf signal exists only when ALU_SEQ_OVF_EN is defined.
interface alu_nibble_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] r;
   logic             c_out;
   logic             zero;
`ifdef ALU_SEQ_OVF_EN
   logic             ovf;
`endif

`ifdef ALU_SEQ_OVF_EN
   modport master (
      output start, op, a, b,
      input  ready, done, r, c_out, zero, ovf
   );
   modport slave (
      input  start, op, a, b,
      output ready, done, r, c_out, zero, ovf
   );
`else
   modport master (
      output start, op, a, b,
      input  ready, done, r, c_out, zero
   );
   modport slave (
      input  start, op, a, b,
      output ready, done, r, c_out, zero
   );
`endif
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Drives a shared 4-bit ALU slice one nibble per cycle, rippling the carry.
// Optional signed overflow / signed slt: define ALU_SEQ_OVF_EN.
module alu_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_nibble_sequencer_if.slave bus,
   output logic [3:0]           slice_a,
   output logic [3:0]           slice_b,
   output logic                 slice_ci,
   output logic [2:0]           slice_op,
   input  logic [3:0]           slice_r,
   input  logic                 slice_c_out
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic [IW-1:0]    idx;
   logic             carry;
   logic [WIDTH-1:0] shadow;

   logic [WIDTH-1:0] res_now;
   logic [WIDTH-1:0] pub_r;
   logic             pub_c;
   logic             less;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic             is_and;
   logic             is_or;
   logic             is_add;
   logic             is_sub;
   logic             is_slt;
`ifdef ALU_SEQ_OVF_EN
   logic             ovf_now;
   logic             pub_ovf;
`endif

   assign is_and = (op_q == OP_AND);
   assign is_or  = (op_q == OP_OR);
   assign is_add = (op_q == OP_ADD);
   assign is_sub = (op_q == OP_SUB);
   assign is_slt = (op_q == OP_SLT);

   // Select current nibble and merge the slice result into the shadow.
   always_comb begin
      nib_a   = 4'h0;
      nib_b   = 4'h0;
      res_now = shadow;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx == IW'(i)) begin
            nib_a = a_q[4*i +: 4];
            nib_b = b_q[4*i +: 4];
            res_now[4*i +: 4] = slice_r;
         end
      end
   end

   // Slice drive; everything is quiet outside RUN.
   always_comb begin
      slice_a  = 4'h0;
      slice_b  = 4'h0;
      slice_ci = 1'b0;
      slice_op = 3'b000;
      if (state == RUN) begin
         slice_a  = nib_a;
         slice_b  = nib_b;
         slice_ci = carry;
         unique case (1'b1)
            is_and, is_or,
            is_add, is_sub: slice_op = op_q;
            is_slt:         slice_op = OP_SUB;
            default:        slice_op = 3'b000;
         endcase
      end
   end

   // Final result, carry and overflow as seen on the last RUN edge.
   always_comb begin
`ifdef ALU_SEQ_OVF_EN
      ovf_now = 1'b0;
      if (is_add)
         ovf_now = (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                   (res_now[WIDTH-1] != a_q[WIDTH-1]);
      else if (is_sub || is_slt)
         ovf_now = (a_q[WIDTH-1] != b_q[WIDTH-1]) &
                   (res_now[WIDTH-1] != a_q[WIDTH-1]);
      less    = res_now[WIDTH-1] ^ ovf_now;
      pub_ovf = ovf_now;
`else
      less = ~slice_c_out;
`endif
      pub_r = '0;
      pub_c = 1'b0;
      unique case (1'b1)
         is_and, is_or: pub_r = res_now;
         is_add, is_sub: begin
            pub_r = res_now;
            pub_c = slice_c_out;
         end
         is_slt: begin
            pub_r[0] = less;
            pub_c    = slice_c_out;
         end
         default: begin
            pub_r = '0;
            pub_c = 1'b0;
         end
      endcase
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         bus.ready <= 1'b1;
         bus.done  <= 1'b0;
         bus.r     <= '0;
         bus.c_out <= 1'b0;
         bus.zero  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
         bus.ovf   <= 1'b0;
`endif
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 3'b000;
         idx       <= '0;
         carry     <= 1'b0;
         shadow    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_q       <= bus.a;
                  b_q       <= bus.b;
                  op_q      <= bus.op;
                  idx       <= '0;
                  carry     <= (bus.op == OP_SUB) || (bus.op == OP_SLT);
                  bus.ready <= 1'b0;
                  state     <= RUN;
               end
            end
            RUN: begin
               shadow <= res_now;
               carry  <= slice_c_out;
               idx    <= idx + 1'b1;
               if (idx == LAST) begin
                  bus.r     <= pub_r;
                  bus.c_out <= pub_c;
                  bus.zero  <= (pub_r == '0);
`ifdef ALU_SEQ_OVF_EN
                  bus.ovf   <= pub_ovf;
`endif
                  bus.done  <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               bus.done  <= 1'b0;
               bus.ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
